// File: rtl/bcd_count_ctrl_pkg.sv
// Shared definitions for the BCD count controller: command op codes,
// FSM state encodings and small per-digit BCD helpers.
package bcd_count_ctrl_pkg;

    typedef logic [1:0] cmd_op_t;
    typedef logic [1:0] ctrl_state_t;

    localparam cmd_op_t OP_LOAD  = 2'b00;
    localparam cmd_op_t OP_START = 2'b01;
    localparam cmd_op_t OP_STOP  = 2'b10;
    localparam cmd_op_t OP_CLEAR = 2'b11;

    localparam ctrl_state_t ST_IDLE   = 2'd0;
    localparam ctrl_state_t ST_RUN    = 2'd1;
    localparam ctrl_state_t ST_FINISH = 2'd2;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // True when a nibble holds a legal BCD digit.
    function automatic logic bcd_nibble_ok(input logic [3:0] nib);
        return nib <= BCD_MAX;
    endfunction

    // One BCD step of a single digit; wraps 9->0 going up and 0->9 going down.
    function automatic logic [3:0] bcd_step(input logic [3:0] val, input logic up);
        logic [3:0] res;
        if (up) begin
            res = (val >= BCD_MAX) ? 4'd0 : val + 4'd1;
        end else begin
            res = (val == 4'd0) ? BCD_MAX : val - 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One cascadable BCD digit. carry_in doubles as "this digit steps when the
// chain steps"; carry_out tells the next digit up that this one rolls over.
// next_value exposes the post-step value so the controller can compare the
// whole chain against a target before committing the step.
module bcd_digit
    import bcd_count_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       up_down,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       carry_in,
    output logic       carry_out,
    output logic [3:0] value,
    output logic [3:0] next_value
);

    logic at_term;

    assign at_term    = up_down ? (value == BCD_MAX) : (value == 4'd0);
    assign carry_out  = carry_in & at_term;
    assign next_value = carry_in ? bcd_step(value, up_down) : value;

    // Digit register: load has priority over a chain step.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= 4'd0;
        end else if (load) begin
            value <= load_val;
        end else if (en && carry_in) begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/bcd_count_ctrl.sv
// Command-driven sequencer for a chain of BCD digits. Steps the chain once
// per prescaled tick toward a latched target, with wrap or saturate at the
// terminal value, and reports done / wrap / err as single-cycle pulses.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | count held; LOAD / START / CLEAR take effect
//   ST_RUN    | stepping on each prescaled tick; STOP / CLEAR abort
//   ST_FINISH | single cycle with done high, commands not accepted
module bcd_count_ctrl
    import bcd_count_ctrl_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic                  cmd_up_down,
    input  logic                  cmd_wrap,
    input  logic [4*DIGITS-1:0]   cmd_data,
    output logic [4*DIGITS-1:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap,
    output logic                  err
);

    localparam int W     = 4 * DIGITS;
    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    ctrl_state_t      state;
    ctrl_state_t      state_nxt;
    logic             dir_q;
    logic             wrap_q;
    logic [W-1:0]     target_q;
    logic [PSC_W-1:0] psc_q;
    logic [PSC_W-1:0] psc_nxt;

    logic [DIGITS:0]  carry;
    logic [W-1:0]     next_count;

    logic             accept;
    logic             data_ok;
    logic             tick;
    logic             at_term;
    logic             at_target;

    logic             ld_en;
    logic [W-1:0]     ld_val;
    logic             step_en;
    logic             latch_start;
    logic             err_set;
    logic             wrap_set;

    assign cmd_ready = (state != ST_FINISH);
    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_FINISH);

    assign accept    = cmd_valid & cmd_ready;
    assign tick      = (psc_q == PSC_LAST);
    assign at_target = (count == target_q);

    // Digit 0 always sees a step request so next_count is the full +/-1 value.
    assign carry[0] = 1'b1;
    assign at_term  = carry[DIGITS];

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .clk        (clk),
                .reset      (reset),
                .en         (step_en),
                .up_down    (dir_q),
                .load       (ld_en),
                .load_val   (ld_val[4*g +: 4]),
                .carry_in   (carry[g]),
                .carry_out  (carry[g+1]),
                .value      (count[4*g +: 4]),
                .next_value (next_count[4*g +: 4])
            );
        end
    endgenerate

    // Reject LOAD / START payloads containing any nibble above 9.
    always_comb begin
        data_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_nibble_ok(cmd_data[4*i +: 4])) begin
                data_ok = 1'b0;
            end
        end
    end

    // Next-state, chain control and pulse requests.
    always_comb begin
        state_nxt   = state;
        psc_nxt     = psc_q;
        ld_en       = 1'b0;
        ld_val      = '0;
        step_en     = 1'b0;
        latch_start = 1'b0;
        err_set     = 1'b0;
        wrap_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            if (data_ok) begin
                                ld_en  = 1'b1;
                                ld_val = cmd_data;
                            end else begin
                                err_set = 1'b1;
                            end
                        end
                        OP_START: begin
                            if (data_ok) begin
                                latch_start = 1'b1;
                                psc_nxt     = '0;
                                state_nxt   = ST_RUN;
                            end else begin
                                err_set = 1'b1;
                            end
                        end
                        OP_CLEAR: ld_en = 1'b1;
                        default:  ;
                    endcase
                end
            end
            ST_RUN: begin
                if (accept && cmd_op == OP_STOP) begin
                    state_nxt = ST_IDLE;
                end else if (accept && cmd_op == OP_CLEAR) begin
                    ld_en     = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    // LOAD / START while running only flag an error.
                    err_set = accept;
                    // count can only sit on target here if START found it there.
                    if (at_target) begin
                        state_nxt = ST_FINISH;
                    end else if (tick) begin
                        psc_nxt = '0;
                        if (at_term && !wrap_q) begin
                            state_nxt = ST_FINISH;
                        end else begin
                            step_en  = 1'b1;
                            wrap_set = at_term;
                            if (next_count == target_q) begin
                                state_nxt = ST_FINISH;
                            end
                        end
                    end else begin
                        psc_nxt = psc_q + 1'b1;
                    end
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State, latched run parameters, prescaler and registered pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            dir_q    <= 1'b0;
            wrap_q   <= 1'b0;
            target_q <= '0;
            psc_q    <= '0;
            err      <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            state <= state_nxt;
            psc_q <= psc_nxt;
            err   <= err_set;
            wrap  <= wrap_set;
            if (latch_start) begin
                dir_q    <= cmd_up_down;
                wrap_q   <= cmd_wrap;
                target_q <= cmd_data;
            end
        end
    end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Bench for bcd_count_ctrl: two instances (PRESCALE 1 and 3) share one
// command bus; a decimal-integer model of each is compared every cycle, and
// directed scenarios add hand-computed literal checks.
module tb_bcd_count_ctrl;

    localparam int MAXV = 99;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_FIN  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic       cmd_up_down = 1'b0;
    logic       cmd_wrap = 1'b0;
    logic [7:0] cmd_data = 8'h00;

    logic       ready_a, busy_a, done_a, wrap_a, err_a;
    logic [7:0] count_a;
    logic       ready_b, busy_b, done_b, wrap_b, err_b;
    logic [7:0] count_b;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    logic [7:0] seq_up   [5] = '{8'h08, 8'h09, 8'h10, 8'h11, 8'h12};
    logic [7:0] seq_dn   [3] = '{8'h00, 8'h99, 8'h98};
    logic [7:0] seq_sat  [3] = '{8'h98, 8'h99, 8'h99};
    logic [7:0] seq_psc  [6] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02};

    always #5 clk = ~clk;

    bcd_count_ctrl #(.DIGITS(2), .PRESCALE(1)) dut_a (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready_a),
        .cmd_op(cmd_op), .cmd_up_down(cmd_up_down), .cmd_wrap(cmd_wrap),
        .cmd_data(cmd_data), .count(count_a), .busy(busy_a), .done(done_a),
        .wrap(wrap_a), .err(err_a)
    );

    bcd_count_ctrl #(.DIGITS(2), .PRESCALE(3)) dut_b (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready_b),
        .cmd_op(cmd_op), .cmd_up_down(cmd_up_down), .cmd_wrap(cmd_wrap),
        .cmd_data(cmd_data), .count(count_b), .busy(busy_b), .done(done_b),
        .wrap(wrap_b), .err(err_b)
    );

    typedef struct {
        int st;
        int c;
        bit dir;
        bit wrp;
        int tgt;
        int pc;
        bit e_err;
        bit e_wrap;
    } mdl_t;

    mdl_t m_a;
    mdl_t m_b;

    function automatic bit bcd_ok(input logic [7:0] d);
        return (d[3:0] <= 4'd9) && (d[7:4] <= 4'd9);
    endfunction

    function automatic int bcd2int(input logic [7:0] d);
        return int'(d[7:4]) * 10 + int'(d[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    // Behavioural model on a decimal integer count.
    function automatic mdl_t mstep(input mdl_t s, input int p);
        bit acc;
        bit term;
        int dv;
        if (reset) begin
            s.st = S_IDLE; s.c = 0; s.dir = 0; s.wrp = 0;
            s.tgt = 0; s.pc = 0; s.e_err = 0; s.e_wrap = 0;
            return s;
        end
        s.e_err  = 0;
        s.e_wrap = 0;
        acc = cmd_valid && (s.st != S_FIN);
        dv  = bcd2int(cmd_data);
        if (s.st == S_FIN) begin
            s.st = S_IDLE;
        end else if (s.st == S_IDLE) begin
            if (acc) begin
                if (cmd_op == 2'b00) begin
                    if (bcd_ok(cmd_data)) s.c = dv; else s.e_err = 1;
                end else if (cmd_op == 2'b01) begin
                    if (bcd_ok(cmd_data)) begin
                        s.dir = cmd_up_down; s.wrp = cmd_wrap; s.tgt = dv;
                        s.pc = 0; s.st = S_RUN;
                    end else begin
                        s.e_err = 1;
                    end
                end else if (cmd_op == 2'b11) begin
                    s.c = 0;
                end
            end
        end else begin
            if (acc && cmd_op == 2'b10) begin
                s.st = S_IDLE;
            end else if (acc && cmd_op == 2'b11) begin
                s.c = 0;
                s.st = S_IDLE;
            end else begin
                if (acc) s.e_err = 1;
                if (s.c == s.tgt) begin
                    s.st = S_FIN;
                end else if (s.pc == p - 1) begin
                    s.pc = 0;
                    term = s.dir ? (s.c == MAXV) : (s.c == 0);
                    if (term && !s.wrp) begin
                        s.st = S_FIN;
                    end else begin
                        s.c = s.dir ? (s.c + 1) % (MAXV + 1) : (s.c + MAXV) % (MAXV + 1);
                        s.e_wrap = term;
                        if (s.c == s.tgt) s.st = S_FIN;
                    end
                end else begin
                    s.pc = s.pc + 1;
                end
            end
        end
        return s;
    endfunction

    always @(posedge clk) begin
        m_a = mstep(m_a, 1);
        m_b = mstep(m_b, 3);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string nm, input logic [7:0] c, input logic r, input logic b,
                       input logic d, input logic w, input logic e, input mdl_t s);
        check({nm, ".count"}, 32'(c), 32'(int2bcd(s.c)));
        check({nm, ".cmd_ready"}, 32'(r), 32'(s.st != S_FIN));
        check({nm, ".busy"}, 32'(b), 32'(s.st == S_RUN));
        check({nm, ".done"}, 32'(d), 32'(s.st == S_FIN));
        check({nm, ".wrap"}, 32'(w), 32'(s.e_wrap));
        check({nm, ".err"}, 32'(e), 32'(s.e_err));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_a", count_a, ready_a, busy_a, done_a, wrap_a, err_a, m_a);
            cmp("model_b", count_b, ready_b, busy_b, done_b, wrap_b, err_b, m_b);
        end
    end

    task automatic do_reset();
        cmd_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic ud, input logic wr, input logic [7:0] d);
        cmd_op = op; cmd_up_down = ud; cmd_wrap = wr; cmd_data = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // 1. reset state
        do_reset();
        chk_en = 1'b1;
        check("rst.count", 32'(count_a), 32'h00);
        check("rst.busy", 32'(busy_a), 0);
        check("rst.done", 32'(done_a), 0);
        check("rst.wrap", 32'(wrap_a), 0);
        check("rst.err", 32'(err_a), 0);
        check("rst.ready", 32'(ready_a), 1);

        // 2. count up 07 -> 12
        send(2'b00, 1'b0, 1'b0, 8'h07);
        check("up.load", 32'(count_a), 32'h07);
        send(2'b01, 1'b1, 1'b1, 8'h12);
        check("up.busy", 32'(busy_a), 1);
        check("up.start_count", 32'(count_a), 32'h07);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("up.seq", 32'(count_a), 32'(seq_up[i]));
            check("up.done", 32'(done_a), 32'(i == 4));
        end
        check("up.busy_end", 32'(busy_a), 0);
        check("up.ready_fin", 32'(ready_a), 0);
        @(negedge clk);
        check("up.done_drop", 32'(done_a), 0);
        check("up.ready_back", 32'(ready_a), 1);

        // 3. count down with wrap 01 -> 98
        do_reset();
        send(2'b00, 1'b0, 1'b0, 8'h01);
        send(2'b01, 1'b0, 1'b1, 8'h98);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("dn.seq", 32'(count_a), 32'(seq_dn[i]));
            check("dn.wrap", 32'(wrap_a), 32'(i == 1));
            check("dn.done", 32'(done_a), 32'(i == 2));
        end

        // 3b. saturate at 99
        do_reset();
        send(2'b00, 1'b0, 1'b0, 8'h97);
        send(2'b01, 1'b1, 1'b0, 8'h05);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sat.seq", 32'(count_a), 32'(seq_sat[i]));
            check("sat.wrap", 32'(wrap_a), 0);
            check("sat.done", 32'(done_a), 32'(i == 2));
        end
        @(negedge clk);
        check("sat.hold", 32'(count_a), 32'h99);

        // 4. illegal LOAD, START while running, STOP on a tick
        do_reset();
        send(2'b00, 1'b0, 1'b0, 8'h12);
        send(2'b00, 1'b0, 1'b0, 8'h1A);
        check("bad_load.err", 32'(err_a), 1);
        check("bad_load.count", 32'(count_a), 32'h12);
        @(negedge clk);
        check("bad_load.err_drop", 32'(err_a), 0);
        send(2'b01, 1'b1, 1'b1, 8'h50);
        @(negedge clk);
        check("run.count13", 32'(count_a), 32'h13);
        send(2'b01, 1'b1, 1'b1, 8'h30);
        check("run_start.err", 32'(err_a), 1);
        check("run_start.busy", 32'(busy_a), 1);
        check("run_start.count", 32'(count_a), 32'h14);
        send(2'b10, 1'b0, 1'b0, 8'h00);
        check("stop.count", 32'(count_a), 32'h14);
        check("stop.busy", 32'(busy_a), 0);
        check("stop.done", 32'(done_a), 0);
        @(negedge clk);
        check("stop.hold", 32'(count_a), 32'h14);
        check("stop.no_done", 32'(done_a), 0);
        send(2'b01, 1'b1, 1'b1, 8'h9F);
        check("bad_start.err", 32'(err_a), 1);
        check("bad_start.busy", 32'(busy_a), 0);
        send(2'b00, 1'b0, 1'b0, 8'h25);
        send(2'b01, 1'b1, 1'b1, 8'h25);
        check("eq.busy", 32'(busy_a), 1);
        @(negedge clk);
        check("eq.done", 32'(done_a), 1);
        check("eq.count", 32'(count_a), 32'h25);

        // 5. PRESCALE=3 instance, 00 -> 02
        do_reset();
        send(2'b01, 1'b1, 1'b1, 8'h02);
        check("psc.busy", 32'(busy_b), 1);
        check("psc.count0", 32'(count_b), 32'h00);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("psc.seq", 32'(count_b), 32'(seq_psc[i]));
            check("psc.done", 32'(done_b), 32'(i == 5));
        end

        // 6. reset mid-run, then CLEAR mid-run
        do_reset();
        send(2'b00, 1'b0, 1'b0, 8'h40);
        send(2'b01, 1'b1, 1'b1, 8'h99);
        repeat (5) @(negedge clk);
        check("mid.count45", 32'(count_a), 32'h45);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst.count", 32'(count_a), 32'h00);
        check("mid_rst.busy", 32'(busy_a), 0);
        check("mid_rst.done", 32'(done_a), 0);
        check("mid_rst.wrap", 32'(wrap_a), 0);
        check("mid_rst.ready", 32'(ready_a), 1);
        send(2'b00, 1'b0, 1'b0, 8'h30);
        send(2'b01, 1'b1, 1'b1, 8'h99);
        repeat (2) @(negedge clk);
        check("clr.pre", 32'(count_a), 32'h32);
        send(2'b11, 1'b0, 1'b0, 8'h00);
        check("clr.count", 32'(count_a), 32'h00);
        check("clr.busy", 32'(busy_a), 0);
        check("clr.done", 32'(done_a), 0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bcd_count_ctrl.md
Name: bcd_count_ctrl

Overview:
Command-driven sequencer for a chain of DIGITS BCD up/down digit counters.
- Accepts LOAD / START / STOP / CLEAR commands over a valid/ready interface.
- Steps the chain once per prescaled tick toward a target value.
- Handles wrap vs. saturate at the terminal value.
- Reports completion, wrap events and rejected commands as single-cycle pulses.
Sits between control logic and the BCD digit counters that drive displays or timers.

Parameters:
DIGITS, 4, number of cascaded BCD digits (count width = 4*DIGITS).
PRESCALE, 1, enabled clocks per count step (>=1).

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at rising edge
cmd_op  in  2  00 LOAD, 01 START, 10 STOP, 11 CLEAR
cmd_up_down  in  1  START only: 1 = count up, 0 = count down
cmd_wrap  in  1  START only: 1 = wrap at terminal, 0 = saturate and finish
cmd_data  in  4*DIGITS  LOAD: preset value; START: target value (packed BCD, digit 0 = LSBs)
count  out  4*DIGITS  current packed BCD count
busy  out  1  high while state == RUN
done  out  1  one-cycle pulse, high exactly in FINISH state
wrap  out  1  one-cycle pulse, registered on the edge a wrap occurs
err  out  1  one-cycle pulse for a rejected command

Behaviour:
- Reset: state=IDLE, count=0, prescale cnt=0, latched dir/wrap/target=0; busy=done=wrap=err=0; cmd_ready=1.
- FSM states:
  - IDLE: count held.
  - RUN: counting.
  - FINISH: one cycle, then IDLE unconditionally.
- cmd_ready = (state != FINISH). A handshake consumes the command regardless of validity.
- Commands in IDLE:
  - LOAD: count <= cmd_data.
  - START: latch dir, wrap, target; prescale cnt <= 0; state <= RUN.
  - STOP: no-op.
  - CLEAR: count <= 0.
- Commands in RUN:
  - STOP: state <= IDLE; count held.
  - CLEAR: count <= 0; state <= IDLE.
  - LOAD / START: err pulse, no other effect.
- Illegal BCD: any cmd_data nibble > 9 on LOAD or START gives an err pulse and no effect.
- Tick: in RUN, tick = (prescale cnt == PRESCALE-1). Prescale cnt wraps to 0 on tick. With PRESCALE=1, every RUN cycle ticks.
- Step on tick: next = count +/-1 in BCD, with digit carry/borrow rippling through the chain.
  - Terminal value: all-9s when counting up, all-0s when counting down.
  - At terminal with wrap=1: count wraps to all-0s / all-9s and the wrap pulse asserts.
  - At terminal with wrap=0: count held, state <= FINISH.
  - If next == target: count <= next, state <= FINISH.
- START with count == target already: RUN lasts one cycle. At the first RUN edge, the FSM goes to FINISH without stepping, regardless of tick.
- Latency: START accepted at edge E0 gives busy high after E0. With PRESCALE=P, the first count change occurs at edge E0+P.
- Simultaneous events: an accepted STOP/CLEAR beats a same-cycle tick; the tick is discarded.
- Reset asserted mid-RUN or mid-FINISH: the next edge returns to the full reset state, and done is suppressed.
- BCD invariant: every count nibble stays in 0..9 at all times.

Decomposition:
- Shared defines file bcd_ctrl_defs:
  - op codes OP_LOAD/OP_START/OP_STOP/OP_CLEAR
  - state encodings ST_IDLE/ST_RUN/ST_FINISH
  - BCD_MAX = 4'd9
- Sub-module bcd_digit: one 4-bit BCD digit with en, up_down, load, load_val, carry/borrow in/out. It is instantiated DIGITS times via generate, and the controller drives the enables and the chain carry.
- Target compare and BCD-validity check stay in bcd_count_ctrl.

Test Plan:
Benches use DIGITS=2 and PRESCALE=1 unless stated otherwise.
1. Reset held 2 cycles -> count=8'h00, busy=0, done=0, wrap=0, err=0, cmd_ready=1.
2. LOAD 8'h07, then START up, wrap=1, target 8'h12 -> count 08,09,10,11,12 on consecutive edges; done high for exactly the cycle count first reads 12; busy drops; FSM back to IDLE.
3. LOAD 8'h01, then START down, wrap=1, target 8'h98 -> count 00, 99 (wrap pulse on that cycle), 98 with done.
   Saturate case: LOAD 8'h97, then START up, wrap=0, target 8'h05 -> count 98, 99, then done with count held at 99 and wrap never high.
4. LOAD 8'h1A -> err pulse, count unchanged.
   During RUN, issue START -> err pulse, run continues.
   During RUN, STOP on a tick cycle -> count frozen at its pre-tick value, busy=0, no done.
5. PRESCALE=3: START up from 8'h00, target 8'h02 -> count changes exactly every 3 cycles; done 6 cycles after the accept edge.
6. Assert reset mid-RUN at count 8'h45 -> next edge count=00, state IDLE, no done/wrap pulse.
   CLEAR in RUN -> count=00, busy=0 next cycle.
